// File: rtl/drq_trigger_unit_pkg.sv
// Shared definitions for the DMA-request trigger unit: edge-mode encodings,
// parameter range limits and the edge-event helper.
package drq_trigger_unit_pkg;

    typedef enum logic [1:0] {
        MODE_RISE   = 2'b00,
        MODE_FALL   = 2'b01,
        MODE_BOTH   = 2'b10,
        MODE_LEGACY = 2'b11
    } edge_mode_e;

    localparam int unsigned CHANNELS_MIN    = 1;
    localparam int unsigned CHANNELS_MAX    = 8;
    localparam int unsigned COUNT_WIDTH_MIN = 1;
    localparam int unsigned COUNT_WIDTH_MAX = 8;

    // Raw edge detection for one channel; legacy mode watches rising edges.
    function automatic logic edge_event(input edge_mode_e mode,
                                        input logic       prev,
                                        input logic       cur);
        logic ev;
        ev = 1'b0;
        case (mode)
            MODE_RISE:   ev = !prev && cur;
            MODE_FALL:   ev = prev && !cur;
            MODE_BOTH:   ev = prev != cur;
            MODE_LEGACY: ev = !prev && cur;
            default:     ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/drq_channel.sv
// One DMA-request channel: edge detection, pending counter with saturation,
// sticky overflow and registered DRQ.
module drq_channel
    import drq_trigger_unit_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic                   enable,
    input  logic [1:0]             edge_mode,
    input  logic                   dma_acknowledge_n,
    input  logic                   overflow_clear,
    output logic                   dma_request,
    output logic [COUNT_WIDTH-1:0] pending_count,
    output logic                   overflow
);

    localparam logic [COUNT_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] PEND_ONE = COUNT_WIDTH'(1);

    logic                   prev_q,  prev_d;
    logic                   ack_q,   ack_d;
    logic                   armed_q, armed_d;
    logic [COUNT_WIDTH-1:0] pend_q,  pend_d;
    logic                   drq_q,   drq_d;
    logic                   ovf_q,   ovf_d;

    edge_mode_e mode;
    logic       evt;
    logic       ack_start;
    logic       ovf_set;

    // Next-state: event/ack detection, pending update, overflow and DRQ.
    always_comb begin
        prev_d    = trigger;
        ack_d     = dma_acknowledge_n;
        armed_d   = 1'b1;
        mode      = edge_mode_e'(edge_mode);
        evt       = armed_q && enable && edge_event(mode, prev_q, trigger);
        ack_start = armed_q && enable && ack_q && !dma_acknowledge_n;
        pend_d    = pend_q;
        ovf_set   = 1'b0;

        if (!enable) begin
            pend_d = '0;
        end else if (mode == MODE_LEGACY) begin
            if (!dma_acknowledge_n) begin
                pend_d = '0;
            end else if (evt) begin
                pend_d = PEND_ONE;
            end
        end else if (evt && !ack_start) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (ack_start && !evt) begin
            if (pend_q != '0) begin
                pend_d = pend_q - PEND_ONE;
            end
        end

        // A set condition outranks a clear in the same cycle.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (overflow_clear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        drq_d = (pend_d != '0) && dma_acknowledge_n;
    end

    // State registers; reset primes prev/ack high so release creates no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q  <= 1'b1;
            ack_q   <= 1'b1;
            armed_q <= 1'b0;
            pend_q  <= '0;
            drq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            ack_q   <= ack_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            drq_q   <= drq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dma_request   = drq_q;
    assign pending_count = pend_q;
    assign overflow      = ovf_q;

endmodule

// File: rtl/drq_trigger_unit.sv
// Top level: slices the per-channel buses onto independent drq_channel
// instances.
module drq_trigger_unit
    import drq_trigger_unit_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             trigger,
    input  logic [CHANNELS-1:0]             enable,
    input  logic [2*CHANNELS-1:0]           edge_mode,
    input  logic [CHANNELS-1:0]             dma_acknowledge_n,
    input  logic [CHANNELS-1:0]             overflow_clear,
    output logic [CHANNELS-1:0]             dma_request,
    output logic [CHANNELS*COUNT_WIDTH-1:0] pending_count,
    output logic [CHANNELS-1:0]             overflow
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("drq_trigger_unit: CHANNELS out of range");
    end
    if (COUNT_WIDTH < COUNT_WIDTH_MIN || COUNT_WIDTH > COUNT_WIDTH_MAX) begin : g_bad_width
        $error("drq_trigger_unit: COUNT_WIDTH out of range");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        drq_channel #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_ch (
            .clock            (clock),
            .reset            (reset),
            .trigger          (trigger[i]),
            .enable           (enable[i]),
            .edge_mode        (edge_mode[2*i +: 2]),
            .dma_acknowledge_n(dma_acknowledge_n[i]),
            .overflow_clear   (overflow_clear[i]),
            .dma_request      (dma_request[i]),
            .pending_count    (pending_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .overflow         (overflow[i])
        );
    end

endmodule

// File: tb/tb_drq_trigger_unit.sv
// Directed bench for drq_trigger_unit: table of channel-0 vectors for the
// counting mode plus hand sequences for reset, mode switching and legacy mode.
module tb_drq_trigger_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  trigger;
    logic [3:0]  enable;
    logic [7:0]  edge_mode;
    logic [3:0]  dack_n;
    logic [3:0]  ovf_clr;
    logic [3:0]  drq;
    logic [11:0] pend;
    logic [3:0]  ovf;

    drq_trigger_unit #(
        .CHANNELS   (4),
        .COUNT_WIDTH(3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .trigger          (trigger),
        .enable           (enable),
        .edge_mode        (edge_mode),
        .dma_acknowledge_n(dack_n),
        .overflow_clear   (ovf_clr),
        .dma_request      (drq),
        .pending_count    (pend),
        .overflow         (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       trig;
        logic       en;
        logic       dack;
        logic       clr;
        logic       e_drq;
        logic [2:0] e_pend;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    function automatic void add(input logic t, input logic e, input logic d,
                                input logic c, input logic x_drq,
                                input logic [2:0] x_pend, input logic x_ovf);
        vec_t v;
        v.trig = t; v.en = e; v.dack = d; v.clr = c;
        v.e_drq = x_drq; v.e_pend = x_pend; v.e_ovf = x_ovf;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ch0(input string nm, input logic t, input logic d,
                       input logic x_drq, input logic [2:0] x_pend,
                       input logic x_ovf);
        trigger[0] = t;
        dack_n[0]  = d;
        step();
        check({nm, ".drq"},  32'(drq[0]),    32'(x_drq));
        check({nm, ".pend"}, 32'(pend[2:0]), 32'(x_pend));
        check({nm, ".ovf"},  32'(ovf[0]),    32'(x_ovf));
    endtask

    initial begin
        reset     = 1'b1;
        trigger   = '0;
        enable    = '1;
        edge_mode = '0;
        dack_n    = '1;
        ovf_clr   = '0;
        #2;
        check("rst.drq",  32'(drq),  32'h0);
        check("rst.pend", 32'(pend), 32'h0);
        check("rst.ovf",  32'(ovf),  32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        step();
        check("arm.pend", 32'(pend), 32'h0);
        check("arm.drq",  32'(drq),  32'h0);

        // Five rising edges, mode 00
        for (int k = 1; k <= 5; k++) begin
            add(1, 1, 1, 0, 1, 3'(k), 0);
            add(0, 1, 1, 0, 1, 3'(k), 0);
        end
        // Five ack pulses, then an ack on empty (floor at 0)
        for (int k = 4; k >= 0; k--) begin
            add(0, 1, 0, 0, 0, 3'(k), 0);
            add(0, 1, 1, 0, (k != 0), 3'(k), 0);
        end
        add(0, 1, 0, 0, 0, 3'd0, 0);
        add(0, 1, 1, 0, 0, 3'd0, 0);
        // Eight rising edges saturate at 7 and set overflow
        for (int k = 1; k <= 8; k++) begin
            add(1, 1, 1, 0, 1, (k > 7) ? 3'd7 : 3'(k), (k == 8));
            add(0, 1, 1, 0, 1, (k > 7) ? 3'd7 : 3'(k), (k == 8));
        end
        add(0, 1, 1, 1, 1, 3'd7, 0);   // clear alone
        add(1, 1, 1, 1, 1, 3'd7, 1);   // clear with 9th edge: set wins
        add(0, 1, 1, 0, 1, 3'd7, 1);
        add(0, 0, 1, 0, 0, 3'd0, 1);   // disable mid-count
        add(0, 1, 1, 0, 0, 3'd0, 1);
        add(1, 1, 1, 0, 1, 3'd1, 1);
        add(0, 1, 1, 0, 1, 3'd1, 1);
        add(1, 1, 0, 0, 0, 3'd1, 1);   // edge and ack-start together
        add(1, 1, 1, 0, 1, 3'd1, 1);
        add(0, 1, 1, 0, 1, 3'd1, 1);
        for (int k = 2; k <= 4; k++) begin
            add(1, 1, 1, 0, 1, 3'(k), 1);
            if (k < 4) add(0, 1, 1, 0, 1, 3'(k), 1);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            trigger[0] = vecs[i].trig;
            enable[0]  = vecs[i].en;
            dack_n[0]  = vecs[i].dack;
            ovf_clr[0] = vecs[i].clr;
            step();
            check($sformatf("vec%0d.drq", i),  32'(drq[0]),    32'(vecs[i].e_drq));
            check($sformatf("vec%0d.pend", i), 32'(pend[2:0]), 32'(vecs[i].e_pend));
            check($sformatf("vec%0d.ovf", i),  32'(ovf[0]),    32'(vecs[i].e_ovf));
            check($sformatf("vec%0d.other", i), 32'({drq[3:1], pend[11:3], ovf[3:1]}), 32'h0);
        end
        ovf_clr[0] = 1'b0;

        // Reset with pending=4: outputs clear immediately, trigger held high
        reset = 1'b1;
        #1;
        check("rstmid.drq",  32'(drq[0]),    32'h0);
        check("rstmid.pend", 32'(pend[2:0]), 32'h0);
        check("rstmid.ovf",  32'(ovf[0]),    32'h0);
        #3 reset = 1'b0;
        ch0("hold_arm", 1, 1, 0, 3'd0, 0);
        ch0("hold_1",   1, 1, 0, 3'd0, 0);

        // Mode 01, then switch to 10 (effective next clock)
        edge_mode[1:0] = 2'b01;
        ch0("fall_r", 1, 1, 0, 3'd0, 0);
        ch0("fall_f", 0, 1, 1, 3'd1, 0);
        edge_mode[1:0] = 2'b10;
        ch0("both_r", 1, 1, 1, 3'd2, 0);
        ch0("both_f", 0, 1, 1, 3'd3, 0);
        ch0("both_ack", 1, 0, 0, 3'd3, 0);
        ch0("both_rel", 1, 1, 1, 3'd3, 0);
        ch0("both_f2",  0, 1, 1, 3'd4, 0);
        ch0("pulse_a",  1, 1, 1, 3'd5, 0);
        ch0("pulse_b",  1, 1, 1, 3'd5, 0);
        ch0("pulse_c",  0, 1, 1, 3'd6, 0);

        // Legacy single-flag mode
        reset = 1'b1;
        edge_mode[1:0] = 2'b11;
        trigger[0] = 1'b0;
        #3 reset = 1'b0;
        ch0("leg_arm",  0, 1, 0, 3'd0, 0);
        ch0("leg_rise", 1, 1, 1, 3'd1, 0);
        ch0("leg_hold", 1, 1, 1, 3'd1, 0);
        ch0("leg_fall", 0, 1, 1, 3'd1, 0);
        ch0("leg_r2",   1, 1, 1, 3'd1, 0);
        ch0("leg_ack",  1, 0, 0, 3'd0, 0);
        ch0("leg_a2",   0, 0, 0, 3'd0, 0);
        ch0("leg_aedge",1, 0, 0, 3'd0, 0);
        ch0("leg_rel",  1, 1, 0, 3'd0, 0);
        ch0("leg_rel2", 1, 1, 0, 3'd0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/drq_trigger_unit.md
DRQ_TRIGGER_UNIT -- requirements
Module: drq_trigger_unit

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent DMA-request channels (1..8).
REQ-002 Parameter COUNT_WIDTH, default 3, width of each channel's pending-request counter (1..8).
REQ-003 clock  input  1  single clock; all state SHALL change only on its rising edge, except reset.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 trigger  input  CHANNELS  per-channel trigger source, for example a timer counter output; synchronous to clock.
REQ-006 enable  input  CHANNELS  per-channel enable.
REQ-007 edge_mode  input  2*CHANNELS  per-channel mode. Encodings: 00 rising, 01 falling, 10 both edges, 11 legacy single-flag.
REQ-008 dma_acknowledge_n  input  CHANNELS  active-low DACK from the DMA controller.
REQ-009 overflow_clear  input  CHANNELS  per-channel synchronous clear of the overflow flag.
REQ-010 dma_request  output  CHANNELS  registered DRQ to the DMA controller.
REQ-011 pending_count  output  CHANNELS*COUNT_WIDTH  registered pending count; channel i occupies bits [i*COUNT_WIDTH +: COUNT_WIDTH].
REQ-012 overflow  output  CHANNELS  sticky flag; set when a trigger event is lost.

Function
REQ-013 Each channel SHALL register trigger (prev) every clock. Events are detected by comparing trigger with prev.
REQ-014 An armed bit SHALL clear on reset and set on the first clock after reset. Events SHALL be ignored while armed=0, so reset never produces a spurious event.
REQ-015 Event definitions:
- Rising: prev=0 and trigger=1.
- Falling: prev=1 and trigger=0.
- Both edges: prev differs from trigger.
- Legacy mode detects rising edges.
REQ-016 Ack-start SHALL be detected as the registered dma_acknowledge_n going 1->0. It is registered the same way as prev and is also gated by armed.
REQ-017 Counting modes (00/01/10), per clock:
- Event only: pending increments.
- Ack-start only: pending decrements, floored at 0.
- Both in the same cycle: pending is unchanged.
REQ-018 Counting modes: an event with pending at its maximum (2^COUNT_WIDTH-1) and no simultaneous ack-start SHALL leave pending at max and set overflow.
REQ-019 Legacy mode (11), with priority in this order:
- While dma_acknowledge_n=0, pending is cleared to 0.
- Otherwise, an event sets pending to 1.
- Otherwise, pending holds.
- Overflow is never set in this mode.
REQ-020 dma_request SHALL update each clock as (next pending != 0) AND (dma_acknowledge_n=1 this cycle). This gives a latency of one clock from the edge-detecting clock to DRQ assertion.
REQ-021 While enable=0, pending SHALL be cleared, dma_request driven 0, and events ignored. prev and the ack register continue to track. overflow holds.
REQ-022 overflow_clear=1 SHALL clear overflow. A set condition in the same cycle SHALL win.
REQ-023 A change of edge_mode SHALL take effect on the next clock. pending is not altered by the change itself.
REQ-024 Channels SHALL be fully independent. No cross-channel priority or arbitration.

Reset
REQ-025 Asserting reset SHALL immediately set:
- dma_request=0, pending_count=0, overflow=0, armed=0.
- prev=1 and the ack register=1.
REQ-026 Reset asserted mid-operation SHALL discard all pending requests. After deassertion the first clock only arms and generates no event.

Structure
REQ-027 Mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEGACY) and the parameter range limits SHALL reside in the shared chipset package.
REQ-028 The per-channel logic SHALL be a sub-module drq_channel, instantiated CHANNELS times via generate. The top level only slices the buses.

Verification
REQ-029 Legacy single-flag behaviour, channel 0 in mode 11:
- Pulse trigger 0->1 -> dma_request[0]=1 one clock later.
- Drive dma_acknowledge_n[0]=0 -> dma_request[0]=0 the same clock, pending=0.
- Edge during ack -> lost, no DRQ after ack release.
REQ-030 Counting with COUNT_WIDTH=3, mode 00:
- 5 rising edges with no ack -> pending_count=5, dma_request=1.
- 5 ack pulses -> pending_count returns to 0 and dma_request=0.
REQ-031 Saturation and sticky overflow:
- 8 rising edges -> pending=7, overflow=1.
- overflow_clear asserted alone -> overflow=0.
- overflow_clear asserted together with a 9th edge -> overflow stays 1.
REQ-032 Simultaneous events, mode 10:
- Trigger toggle in the same cycle as an ack-start with pending=3 -> pending stays 3.
- Both edges of a 2-cycle pulse -> pending increments by 2.
REQ-033 Reset handling:
- Hold trigger=1 through reset deassertion -> no DRQ.
- Assert reset with pending=4 -> all outputs 0 immediately.
- Disable the channel mid-count -> pending=0 next clock, overflow retained.
